vram_hdma_arbiter: RTL and testbench

- Owns the single VRAM port and shares it between three requesters: the video fetcher, a CGB-style HDMA engine (FF51-FF55), and the CPU.
- Implements the HDMA engine: general-purpose DMA, and HBlank DMA that moves one 16-byte block per HBlank.
- Sits between the video unit, the CPU bus decoder and the VRAM instance.
- Stalls the CPU while a DMA block is in flight.

---
 rtl/vram_hdma_arbiter.sv | 219 +++++++++++++++++++++
 tb/tb_vram_hdma_arbiter.sv | 342 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vram_hdma_arbiter.sv
// VRAM port owner: arbitrates video fetch, CGB-style HDMA engine (FF51-FF55) and CPU access.
// The HDMA engine moves BLOCK_BYTES-byte blocks as general DMA or one block per HBlank.
module vram_hdma_arbiter #(
  parameter int BLOCK_BYTES = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        lcd_on,
  input  logic [1:0]  video_mode,
  input  logic        video_rd,
  input  logic [12:0] video_addr,
  input  logic        cpu_sel_vram,
  input  logic        cpu_sel_hdma,
  input  logic [12:0] cpu_addr,
  input  logic        cpu_wr,
  input  logic [7:0]  cpu_di,
  output logic [7:0]  cpu_do,
  output logic        cpu_stall,
  output logic        hdma_rd,
  output logic [15:0] hdma_src,
  input  logic [7:0]  hdma_data,
  output logic [12:0] vram_addr,
  output logic        vram_wr,
  output logic [7:0]  vram_di,
  input  logic [7:0]  vram_do
);

  localparam int CW = $clog2(BLOCK_BYTES);

  typedef enum logic [2:0] {
    S_IDLE,
    S_G_RD,
    S_G_WR,
    S_H_WAIT,
    S_H_RD,
    S_H_WR
  } state_t;

  state_t         state_q, state_d;
  logic [15:0]    src_q, src_d;
  logic [12:0]    dst_q, dst_d;
  logic [6:0]     len_q, len_d;
  logic           cancel_q, cancel_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [7:0]     data_q, data_d;
  logic           wr_first_q, wr_first_d;
  logic [1:0]     mode_prev_q, mode_prev_d;

  logic vid_busy;
  logic in_wr;
  logic in_flight;
  logic hblank_act;
  logic hblank_edge;
  logic last_byte;
  logic byte_done;
  logic hdma_write;
  logic cpu_grant;
  logic [7:0] wr_data;

  assign vid_busy    = lcd_on && (video_mode == 2'b11);
  assign in_wr       = (state_q == S_G_WR) || (state_q == S_H_WR);
  assign in_flight   = (state_q == S_G_RD) || (state_q == S_G_WR) ||
                       (state_q == S_H_RD) || (state_q == S_H_WR);
  assign hblank_act  = (state_q == S_H_WAIT) || (state_q == S_H_RD) || (state_q == S_H_WR);
  assign hblank_edge = lcd_on && (mode_prev_q == 2'b11) && (video_mode == 2'b00);
  assign last_byte   = (cnt_q == CW'(BLOCK_BYTES - 1));
  assign hdma_write  = in_wr && !vid_busy;
  assign cpu_grant   = !vid_busy && !in_wr;
  // Source data is only valid on the first WR cycle; later held cycles use the latched copy.
  assign wr_data     = wr_first_q ? hdma_data : data_q;
  assign byte_done   = hdma_write;

  always_comb begin
    state_d     = state_q;
    src_d       = src_q;
    dst_d       = dst_q;
    len_d       = len_q;
    cancel_d    = cancel_q;
    cnt_d       = cnt_q;
    data_d      = data_q;
    wr_first_d  = 1'b0;
    mode_prev_d = video_mode;

    if (in_wr) begin
      data_d = wr_data;
    end

    if (byte_done) begin
      src_d = src_q + 16'd1;
      dst_d = dst_q + 13'd1;
      cnt_d = cnt_q + CW'(1);
    end

    case (state_q)
      S_IDLE: ;
      S_G_RD: begin
        state_d    = S_G_WR;
        wr_first_d = 1'b1;
      end
      S_G_WR: begin
        if (byte_done) begin
          state_d = S_G_RD;
          if (last_byte) begin
            len_d = len_q - 7'd1;
            if (len_q == 7'd0) begin
              state_d = S_IDLE;
            end
          end
        end
      end
      S_H_WAIT: begin
        if (hblank_edge) begin
          state_d = S_H_RD;
        end
      end
      S_H_RD: begin
        state_d    = S_H_WR;
        wr_first_d = 1'b1;
      end
      S_H_WR: begin
        if (byte_done && last_byte) begin
          len_d = len_q - 7'd1;
          if ((len_q == 7'd0) || cancel_q) begin
            state_d  = S_IDLE;
            cancel_d = 1'b0;
          end else begin
            state_d = S_H_WAIT;
          end
        end else if (byte_done) begin
          state_d = S_H_RD;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (cpu_sel_hdma && cpu_wr) begin
      case (cpu_addr[2:0])
        3'd1: if (!in_flight) src_d = {cpu_di, src_q[7:4], 4'h0};
        3'd2: if (!in_flight) src_d = {src_q[15:8], cpu_di[7:4], 4'h0};
        3'd3: if (!in_flight) dst_d = {cpu_di[4:0], dst_q[7:4], 4'h0};
        3'd4: if (!in_flight) dst_d = {dst_q[12:8], cpu_di[7:4], 4'h0};
        3'd5: begin
          if (state_q == S_IDLE) begin
            len_d    = cpu_di[6:0];
            cnt_d    = '0;
            cancel_d = 1'b0;
            state_d  = cpu_di[7] ? S_H_WAIT : S_G_RD;
          end else if (hblank_act && !cpu_di[7]) begin
            // A block already started runs to completion before the cancel takes effect.
            if (state_q == S_H_WAIT) begin
              state_d  = S_IDLE;
              cancel_d = 1'b0;
            end else begin
              cancel_d = 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      src_q       <= 16'h0000;
      dst_q       <= 13'h0000;
      len_q       <= 7'h7F;
      cancel_q    <= 1'b0;
      cnt_q       <= '0;
      data_q      <= 8'h00;
      wr_first_q  <= 1'b0;
      mode_prev_q <= 2'b00;
    end else begin
      state_q     <= state_d;
      src_q       <= src_d;
      dst_q       <= dst_d;
      len_q       <= len_d;
      cancel_q    <= cancel_d;
      cnt_q       <= cnt_d;
      data_q      <= data_d;
      wr_first_q  <= wr_first_d;
      mode_prev_q <= mode_prev_d;
    end
  end

  assign hdma_rd   = (state_q == S_G_RD) || (state_q == S_H_RD);
  assign hdma_src  = src_q;
  assign cpu_stall = in_flight;

  always_comb begin
    vram_addr = cpu_addr;
    vram_wr   = 1'b0;
    vram_di   = cpu_di;
    if (vid_busy && video_rd) begin
      vram_addr = video_addr;
    end else if (hdma_write) begin
      vram_addr = dst_q;
      vram_wr   = 1'b1;
      vram_di   = wr_data;
    end else if (cpu_grant) begin
      vram_addr = cpu_addr;
      vram_wr   = cpu_wr && cpu_sel_vram;
      vram_di   = cpu_di;
    end
  end

  always_comb begin
    cpu_do = 8'hFF;
    if (cpu_sel_hdma) begin
      if (cpu_addr[2:0] == 3'd5) begin
        cpu_do = {(state_q == S_IDLE), len_q};
      end
    end else if (cpu_sel_vram && cpu_grant) begin
      cpu_do = vram_do;
    end
  end

endmodule

// File: tb/tb_vram_hdma_arbiter.sv
// Scoreboard bench for vram_hdma_arbiter: a transfer-level model queues expected VRAM
// writes, and a monitor pops and compares them whenever the DUT writes VRAM for HDMA.
module tb_vram_hdma_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        lcd_on;
  logic [1:0]  video_mode;
  logic        video_rd;
  logic [12:0] video_addr;
  logic        cpu_sel_vram;
  logic        cpu_sel_hdma;
  logic [12:0] cpu_addr;
  logic        cpu_wr;
  logic [7:0]  cpu_di;
  logic [7:0]  cpu_do;
  logic        cpu_stall;
  logic        hdma_rd;
  logic [15:0] hdma_src;
  logic [7:0]  hdma_data;
  logic [12:0] vram_addr;
  logic        vram_wr;
  logic [7:0]  vram_di;
  logic [7:0]  vram_do;

  always #5 clk = ~clk;

  vram_hdma_arbiter #(.BLOCK_BYTES(16)) dut (
    .clk(clk), .reset(reset), .lcd_on(lcd_on), .video_mode(video_mode),
    .video_rd(video_rd), .video_addr(video_addr), .cpu_sel_vram(cpu_sel_vram),
    .cpu_sel_hdma(cpu_sel_hdma), .cpu_addr(cpu_addr), .cpu_wr(cpu_wr),
    .cpu_di(cpu_di), .cpu_do(cpu_do), .cpu_stall(cpu_stall), .hdma_rd(hdma_rd),
    .hdma_src(hdma_src), .hdma_data(hdma_data), .vram_addr(vram_addr),
    .vram_wr(vram_wr), .vram_di(vram_di), .vram_do(vram_do)
  );

  function automatic logic [7:0] src_byte(input logic [15:0] a);
    return a[7:0] ^ a[15:8] ^ 8'hA5;
  endfunction

  // VRAM array and source bus; the source bus returns garbage except the cycle after a read.
  logic [7:0] vram_mem [0:8191];
  assign vram_do = vram_mem[vram_addr];
  always @(posedge clk) if (vram_wr) vram_mem[vram_addr] <= vram_di;
  always @(posedge clk) hdma_data <= hdma_rd ? src_byte(hdma_src) : 8'($urandom);

  logic [20:0] exp_q[$];
  int compared = 0;
  int mismatched = 0;
  int stall_cycles = 0;

  logic [15:0] m_src;
  logic [12:0] m_dst;
  logic [6:0]  m_len;
  bit          m_active;
  bit          m_cancel;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0h, required %0h", name, act, exp);
    end
  endtask

  task automatic monitor_loop();
    logic [20:0] e;
    forever begin
      @(negedge clk);
      if (!reset) begin
        if (cpu_stall) stall_cycles++;
        if (lcd_on && video_mode == 2'b11 && video_rd) begin
          check("video_addr", 32'(vram_addr), 32'(video_addr));
          check("video_no_wr", 32'(vram_wr), 32'd0);
        end
        if (vram_wr && !(cpu_wr && cpu_sel_vram)) begin
          if (exp_q.size() == 0) begin
            compared++;
            mismatched++;
            $display("FAIL unexpected_wr: got write %0h<=%0h, required no write", vram_addr, vram_di);
          end else begin
            e = exp_q.pop_front();
            check("hdma_wr", 32'({vram_addr, vram_di}), 32'(e));
          end
        end
      end
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic reg_write(input logic [2:0] r, input logic [7:0] v);
    step();
    cpu_sel_hdma = 1'b1; cpu_addr = 13'h1F50 | 13'(r); cpu_wr = 1'b1; cpu_di = v;
    step();
    cpu_sel_hdma = 1'b0; cpu_wr = 1'b0;
  endtask

  task automatic check_ff55(input string name);
    step();
    cpu_sel_hdma = 1'b1; cpu_addr = 13'h1F55;
    @(negedge clk);
    check(name, 32'(cpu_do), 32'({~m_active, m_len}));
    step();
    cpu_sel_hdma = 1'b0;
  endtask

  task automatic vram_cpu_write(input logic [12:0] a, input logic [7:0] v);
    step();
    cpu_sel_vram = 1'b1; cpu_addr = a; cpu_wr = 1'b1; cpu_di = v;
    step();
    cpu_sel_vram = 1'b0; cpu_wr = 1'b0;
  endtask

  task automatic vram_cpu_check(input string name, input logic [12:0] a, input logic [7:0] exp);
    step();
    cpu_sel_vram = 1'b1; cpu_addr = a;
    @(negedge clk);
    check(name, 32'(cpu_do), 32'(exp));
    step();
    cpu_sel_vram = 1'b0;
  endtask

  task automatic wait_idle();
    bit done = 1'b0;
    for (int i = 0; i < 600 && !done; i++) begin
      @(negedge clk);
      if (!cpu_stall) done = 1'b1;
    end
    if (!done) begin
      compared++;
      mismatched++;
      $display("FAIL wait_idle: cpu_stall still 1 after 600 cycles, required 0");
    end
    step();
  endtask

  task automatic set_addr(input logic [15:0] src, input logic [12:0] dst);
    reg_write(3'd1, src[15:8]);
    reg_write(3'd2, src[7:0]);
    reg_write(3'd3, {3'b100, dst[12:8]});
    reg_write(3'd4, dst[7:0]);
    m_src = {src[15:4], 4'h0};
    m_dst = {dst[12:4], 4'h0};
  endtask

  task automatic push_block();
    for (int i = 0; i < 16; i++) begin
      exp_q.push_back({m_dst, src_byte(m_src)});
      m_src = m_src + 16'd1;
      m_dst = m_dst + 13'd1;
    end
  endtask

  task automatic gdma(input logic [6:0] len);
    for (int b = 0; b <= int'(len); b++) push_block();
    m_len = 7'h7F;
    m_active = 1'b0;
    reg_write(3'd5, {1'b0, len});
  endtask

  task automatic hdma_start(input logic [6:0] len);
    m_len = len;
    m_active = 1'b1;
    m_cancel = 1'b0;
    reg_write(3'd5, {1'b1, len});
  endtask

  // One HBlank: mode 11 for a few lines of pixels, then mode 00 long enough for a block.
  task automatic hblank(input bit cancel_mid);
    bit was_active;
    step();
    video_mode = 2'b11;
    repeat (4) step();
    video_mode = 2'b00;
    was_active = m_active;
    if (m_active) push_block();
    if (cancel_mid) begin
      repeat (6) step();
      reg_write(3'd5, 8'h00);
      if (m_active) m_cancel = 1'b1;
    end
    repeat (50) step();
    if (was_active) begin
      if (m_len == 7'd0 || m_cancel) m_active = 1'b0;
      m_cancel = 1'b0;
      m_len = m_len - 7'd1;
    end
  endtask

  task automatic check_drained(input string name);
    check(name, 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    int s0;
    for (int i = 0; i < 8192; i++) vram_mem[i] = 8'h00;
    reset = 1'b1; lcd_on = 1'b0; video_mode = 2'b00; video_rd = 1'b0; video_addr = '0;
    cpu_sel_vram = 1'b0; cpu_sel_hdma = 1'b0; cpu_addr = '0; cpu_wr = 1'b0; cpu_di = '0;
    m_src = '0; m_dst = '0; m_len = 7'h7F; m_active = 1'b0; m_cancel = 1'b0;
    fork
      monitor_loop();
    join_none
    repeat (3) step();
    reset = 1'b0;

    // Reset state
    @(negedge clk);
    check("rst_hdma_rd", 32'(hdma_rd), 32'd0);
    check("rst_vram_wr", 32'(vram_wr), 32'd0);
    check("rst_stall", 32'(cpu_stall), 32'd0);
    check_ff55("rst_ff55");
    step();
    cpu_sel_hdma = 1'b1; cpu_addr = 13'h1F51;
    @(negedge clk);
    check("ff51_read", 32'(cpu_do), 32'hFF);
    step();
    cpu_sel_hdma = 1'b0;

    // General DMA, two blocks, LCD off
    set_addr(16'hC000, 13'h0000);
    s0 = stall_cycles;
    gdma(7'd1);
    wait_idle();
    check("gdma_stall_cycles", 32'(stall_cycles - s0), 32'd64);
    check_ff55("gdma_ff55_done");
    check_drained("gdma_drained");

    // HBlank DMA, three blocks
    lcd_on = 1'b1;
    set_addr(16'($urandom), 13'($urandom));
    hdma_start(7'd2);
    check_ff55("hdma_ff55_start");
    for (int k = 0; k < 3; k++) begin
      s0 = stall_cycles;
      hblank(1'b0);
      check("hdma_block_stall", 32'(stall_cycles - s0), 32'd32);
      @(negedge clk);
      check("hdma_stall_between", 32'(cpu_stall), 32'd0);
      check_ff55("hdma_ff55_block");
    end
    s0 = stall_cycles;
    hblank(1'b0);
    check("hdma_after_done_stall", 32'(stall_cycles - s0), 32'd0);
    check_drained("hdma_drained");

    // Cancel during the second block
    set_addr(16'($urandom), 13'($urandom));
    hdma_start(7'd5);
    hblank(1'b0);
    hblank(1'b1);
    check_ff55("cancel_mid_ff55");
    s0 = stall_cycles;
    hblank(1'b0);
    check("cancel_mid_no_more", 32'(stall_cycles - s0), 32'd0);
    check_drained("cancel_mid_drained");

    // Cancel while waiting for HBlank
    hdma_start(7'd3);
    reg_write(3'd5, 8'h00);
    m_active = 1'b0;
    check_ff55("cancel_wait_ff55");
    s0 = stall_cycles;
    hblank(1'b0);
    check("cancel_wait_no_xfer", 32'(stall_cycles - s0), 32'd0);

    // General DMA started during pixel transfer with the fetcher active
    video_mode = 2'b11; video_rd = 1'b1;
    set_addr(16'($urandom), 13'($urandom));
    gdma(7'd0);
    for (int i = 0; i < 40; i++) begin
      video_addr = 13'($urandom);
      step();
    end
    check("mode3_hold_pending", 32'(exp_q.size()), 32'd16);
    video_mode = 2'b00; video_rd = 1'b0;
    wait_idle();
    check_drained("mode3_drained");

    // CPU VRAM access arbitration
    vram_cpu_write(13'h0100, 8'h11);
    video_mode = 2'b11;
    vram_cpu_write(13'h0100, 8'h22);
    vram_cpu_check("cpu_rd_mode3", 13'h0100, 8'hFF);
    video_mode = 2'b00;
    vram_cpu_check("cpu_wr_dropped", 13'h0100, 8'h11);
    vram_cpu_write(13'h0100, 8'h33);
    vram_cpu_check("cpu_wr_mode0", 13'h0100, 8'h33);
    lcd_on = 1'b0; video_mode = 2'b11;
    vram_cpu_check("cpu_rd_lcd_off", 13'h0100, 8'h33);
    video_mode = 2'b00;

    // Randomized general DMA transfers
    for (int r = 0; r < 4; r++) begin
      lcd_on = 1'($urandom_range(0, 1));
      set_addr(16'($urandom), 13'($urandom));
      gdma(7'($urandom_range(0, 3)));
      wait_idle();
      check_ff55("rand_ff55");
      check_drained("rand_drained");
    end

    // Destination wrap at the top of VRAM
    set_addr(16'($urandom), 13'h1FF0);
    gdma(7'd1);
    wait_idle();
    check_drained("wrap_drained");
    vram_cpu_check("wrap_vram0", 13'h0000, src_byte(m_src - 16'd16));

    // Reset in the middle of a block
    set_addr(16'($urandom), 13'($urandom));
    gdma(7'd3);
    repeat (9) step();
    reset = 1'b1;
    step();
    @(negedge clk);
    check("mid_rst_hdma_rd", 32'(hdma_rd), 32'd0);
    check("mid_rst_vram_wr", 32'(vram_wr), 32'd0);
    check("mid_rst_stall", 32'(cpu_stall), 32'd0);
    step();
    reset = 1'b0;
    exp_q.delete();
    m_src = '0; m_dst = '0; m_len = 7'h7F; m_active = 1'b0; m_cancel = 1'b0;
    check_ff55("mid_rst_ff55");
    gdma(7'd0);
    wait_idle();
    check_drained("post_rst_drained");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

endmodule
